// File: rtl/slink_ph_ecc_tx.sv
// Packet-header ECC generator + small FIFO; optional error injection under SLINK_PH_ECC_ERR_INJ_EN.
// One-cycle latency into an empty FIFO; ph_ready drops when full (no push-through, no bypass).
module slink_ph_ecc_tx #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ph_valid,
  input  logic [23:0]      ph_in,
  output logic             ph_ready,
  output logic             pkt_valid,
  output logic [31:0]      pkt_data,
  input  logic             pkt_ready,
  input  logic             count_clr,
`ifdef SLINK_PH_ECC_ERR_INJ_EN
  input  logic             err_inj_en,
  input  logic [31:0]      err_inj_mask,
`endif
  output logic [CNT_W-1:0] pkt_count
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [5:0]    ecc;
  logic [31:0]   wr_word;

  // Each ecc bit is the parity of the header bits whose column code has that bit set.
  assign ecc[0] = ph_in[0]  ^ ph_in[1]  ^ ph_in[2]  ^ ph_in[4]  ^ ph_in[5]  ^ ph_in[7]  ^
                  ph_in[10] ^ ph_in[11] ^ ph_in[13] ^ ph_in[16] ^ ph_in[20] ^ ph_in[21] ^
                  ph_in[22] ^ ph_in[23];
  assign ecc[1] = ph_in[0]  ^ ph_in[1]  ^ ph_in[3]  ^ ph_in[4]  ^ ph_in[6]  ^ ph_in[8]  ^
                  ph_in[10] ^ ph_in[12] ^ ph_in[14] ^ ph_in[17] ^ ph_in[20] ^ ph_in[21] ^
                  ph_in[22] ^ ph_in[23];
  assign ecc[2] = ph_in[0]  ^ ph_in[2]  ^ ph_in[3]  ^ ph_in[5]  ^ ph_in[6]  ^ ph_in[9]  ^
                  ph_in[11] ^ ph_in[12] ^ ph_in[15] ^ ph_in[18] ^ ph_in[20] ^ ph_in[21] ^
                  ph_in[22];
  assign ecc[3] = ph_in[1]  ^ ph_in[2]  ^ ph_in[3]  ^ ph_in[7]  ^ ph_in[8]  ^ ph_in[9]  ^
                  ph_in[13] ^ ph_in[14] ^ ph_in[15] ^ ph_in[19] ^ ph_in[20] ^ ph_in[21] ^
                  ph_in[23];
  assign ecc[4] = ph_in[4]  ^ ph_in[5]  ^ ph_in[6]  ^ ph_in[7]  ^ ph_in[8]  ^ ph_in[9]  ^
                  ph_in[16] ^ ph_in[17] ^ ph_in[18] ^ ph_in[19] ^ ph_in[20] ^ ph_in[22] ^
                  ph_in[23];
  assign ecc[5] = ph_in[10] ^ ph_in[11] ^ ph_in[12] ^ ph_in[13] ^ ph_in[14] ^ ph_in[15] ^
                  ph_in[16] ^ ph_in[17] ^ ph_in[18] ^ ph_in[19] ^ ph_in[21] ^ ph_in[22] ^
                  ph_in[23];

`ifdef SLINK_PH_ECC_ERR_INJ_EN
  assign wr_word = {2'b00, ecc, ph_in} ^ (err_inj_en ? err_inj_mask : 32'h0);
`else
  assign wr_word = {2'b00, ecc, ph_in};
`endif

  assign full      = (occ == DEPTH);
  assign empty     = (occ == '0);
  assign ph_ready  = enable && !full && !reset;
  assign pkt_valid = !empty;
  assign pkt_data  = pkt_valid ? mem[rd_ptr] : 32'h0;
  assign push      = ph_valid && ph_ready;
  assign pop       = pkt_valid && pkt_ready;

  // Storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || count_clr) begin
      pkt_count <= '0;
    end else if (pop && (pkt_count != '1)) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_slink_ph_ecc_tx.sv
// Scoreboard bench for slink_ph_ecc_tx (small counter width to reach saturation quickly).
module tb_slink_ph_ecc_tx;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             ph_valid = 1'b0;
  logic [23:0]      ph_in = '0;
  logic             ph_ready;
  logic             pkt_valid;
  logic [31:0]      pkt_data;
  logic             pkt_ready = 1'b0;
  logic             count_clr = 1'b0;
  logic [CNT_W-1:0] pkt_count;
  logic             err_inj_en = 1'b0;
  logic [31:0]      err_inj_mask = '0;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_on = 1'b0;

  logic [31:0] exp_q[$];
  int          cnt_m = 0;

  logic [7:0] code_tab [24] = '{
    8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
    8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
    8'h31, 8'h32, 8'h34, 8'h38, 8'h1F, 8'h2F, 8'h37, 8'h3B
  };

  always #5 clk = ~clk;

  slink_ph_ecc_tx #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ph_valid     (ph_valid),
    .ph_in        (ph_in),
    .ph_ready     (ph_ready),
    .pkt_valid    (pkt_valid),
    .pkt_data     (pkt_data),
    .pkt_ready    (pkt_ready),
    .count_clr    (count_clr),
`ifdef SLINK_PH_ECC_ERR_INJ_EN
    .err_inj_en   (err_inj_en),
    .err_inj_mask (err_inj_mask),
`endif
    .pkt_count    (pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] model_word(input logic [23:0] ph);
    logic [7:0] e = 8'h00;
    for (int i = 0; i < 24; i++) begin
      if (ph[i]) e = e ^ code_tab[i];
    end
    return {e, ph};
  endfunction

  // Mid-cycle: compare DUT against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mon_on) begin
      logic m_valid;
      logic m_ready;
      logic m_pop;
      logic [31:0] w;
      m_valid = (exp_q.size() != 0);
      m_ready = enable && !reset && (exp_q.size() < FIFO_DEPTH);
      chk("ph_ready", {31'b0, ph_ready}, {31'b0, m_ready});
      chk("pkt_valid", {31'b0, pkt_valid}, {31'b0, m_valid});
      chk("pkt_count", 32'(pkt_count), 32'(cnt_m));
      m_pop = m_valid && pkt_ready;
      if (m_pop) begin
        w = exp_q.pop_front();
        chk("pkt_data_pop", pkt_data, w);
      end else if (m_valid) begin
        chk("pkt_data_hold", pkt_data, exp_q[0]);
      end else begin
        chk("pkt_data_idle", pkt_data, 32'h0);
      end
      if (reset) begin
        exp_q.delete();
        cnt_m = 0;
      end else begin
        if (count_clr) cnt_m = 0;
        else if (m_pop && cnt_m != CNT_MAX) cnt_m = cnt_m + 1;
        if (ph_valid && m_ready) begin
          w = model_word(ph_in);
          if (err_inj_en) w = w ^ err_inj_mask;
          exp_q.push_back(w);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [23:0] d);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    ph_valid = 1'b1;
    ph_in = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ph_ready;
      @(posedge clk);
      #1;
      n++;
    end
    ph_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2);
    mon_on = 1'b1;
    cyc(1);
    reset = 1'b0;
    enable = 1'b1;

    // Single header, immediate drain.
    pkt_ready = 1'b1;
    push_hdr(24'h000001);
    cyc(2);

    // Fill to full with sink stalled, third push waits until sink resumes.
    pkt_ready = 1'b0;
    push_hdr(24'h800000);
    push_hdr(24'hFFFFFF);
    fork
      push_hdr(24'h000000);
      begin cyc(3); pkt_ready = 1'b1; end
    join
    cyc(4);

    // Hold an entry under backpressure.
    pkt_ready = 1'b0;
    push_hdr(24'h123456);
    cyc(5);
    pkt_ready = 1'b1;
    cyc(2);

    // Disable with two entries buffered; they still drain.
    pkt_ready = 1'b0;
    push_hdr(24'hA5A5A5);
    push_hdr(24'h5A5A5A);
    enable = 1'b0;
    ph_valid = 1'b1;
    ph_in = 24'h0F0F0F;
    cyc(3);
    pkt_ready = 1'b1;
    cyc(4);
    ph_valid = 1'b0;
    enable = 1'b1;

    // Counter saturation, then clear colliding with a pop.
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    for (int i = 0; i < 5; i++) push_hdr(24'(i * 24'h111111));
    cyc(3);
    pkt_ready = 1'b0;
    push_hdr(24'h00ABCD);
    count_clr = 1'b1;
    pkt_ready = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    cyc(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      ph_valid  = 1'($urandom_range(0, 1));
      ph_in     = 24'($urandom);
      pkt_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      count_clr = ($urandom_range(0, 31) == 0);
`ifdef SLINK_PH_ECC_ERR_INJ_EN
      err_inj_en   = ($urandom_range(0, 3) == 0);
      err_inj_mask = $urandom;
`endif
      cyc(1);
    end
    ph_valid = 1'b0;
    count_clr = 1'b0;
    enable = 1'b1;
    err_inj_en = 1'b0;
    pkt_ready = 1'b1;
    cyc(4);

`ifdef SLINK_PH_ECC_ERR_INJ_EN
    // Flip header bit 0 at store time.
    err_inj_en = 1'b1;
    err_inj_mask = 32'h00000001;
    push_hdr(24'h000001);
    err_inj_en = 1'b0;
    err_inj_mask = '0;
    cyc(3);
`endif

    // Reset in the middle of a burst.
    pkt_ready = 1'b0;
    push_hdr(24'h000777);
    push_hdr(24'h000888);
    pkt_ready = 1'b1;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    push_hdr(24'h000001);
    cyc(3);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
